// File: rtl/texel_serializer_if.sv
// Bus bundle between the triangle source / word sink and texel_serializer.
// The master side is the environment (triangle source plus downstream FIFO);
// the slave side is the serializer itself.
interface texel_serializer_if;
  logic [167:0] texel_in;
  logic         texel_last;
  logic         texel_valid;
  logic         texel_ready;
  logic         word_full;
  logic [31:0]  word_out;
  logic         word_write;
  logic         busy;
  logic [15:0]  tri_count;

  modport master (
    output texel_in, texel_last, texel_valid, word_full,
    input  texel_ready, word_out, word_write, busy, tri_count
  );

  modport slave (
    input  texel_in, texel_last, texel_valid, word_full,
    output texel_ready, word_out, word_write, busy, tri_count
  );
endinterface

// File: rtl/texel_serializer.sv
// texel_serializer: turns one 168-bit triangle into a framed stream of
// 32-bit words: FRAME_START, six payload words, and FRAME_END after the
// last triangle of a batch. Writes stall while the downstream FIFO is full.
module texel_serializer #(
  parameter logic [31:0] FRAME_START = 32'd0,
  parameter logic [31:0] FRAME_END   = 32'd1,
  parameter logic [23:0] PAD_VALUE   = 24'd0
) (
  input  logic clk,
  input  logic n_rst,
  texel_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_PAYLOAD,
    S_END
  } state_t;

  state_t       state_q, state_d;
  logic [167:0] texel_q, texel_d;
  logic         last_q, last_d;
  logic [2:0]   index_q, index_d;
  logic [15:0]  triCount_q, triCount_d;
  logic [31:0]  payloadWord;
  logic         wordWrite;

  // State, latched triangle, word index and triangle counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      texel_q    <= '0;
      last_q     <= 1'b0;
      index_q    <= 3'd0;
      triCount_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      texel_q    <= texel_d;
      last_q     <= last_d;
      index_q    <= index_d;
      triCount_q <= triCount_d;
    end
  end

  // Select the payload word for the current index; the final word carries
  // the top 8 colour bits under the pad value.
  always_comb begin
    payloadWord = '0;
    case (index_q)
      3'd0:    payloadWord = texel_q[31:0];
      3'd1:    payloadWord = texel_q[63:32];
      3'd2:    payloadWord = texel_q[95:64];
      3'd3:    payloadWord = texel_q[127:96];
      3'd4:    payloadWord = texel_q[159:128];
      3'd5:    payloadWord = {PAD_VALUE, texel_q[167:160]};
      default: payloadWord = '0;
    endcase
  end

  // Next-state logic and outputs; every step past IDLE waits for a write.
  always_comb begin
    state_d         = state_q;
    texel_d         = texel_q;
    last_d          = last_q;
    index_d         = index_q;
    triCount_d      = triCount_q;
    wordWrite       = (state_q != S_IDLE) && !bus.word_full;
    bus.texel_ready = 1'b0;
    bus.word_out    = '0;
    case (state_q)
      S_IDLE: begin
        bus.texel_ready = 1'b1;
        if (bus.texel_valid) begin
          texel_d = bus.texel_in;
          last_d  = bus.texel_last;
          state_d = S_START;
        end
      end
      S_START: begin
        bus.word_out = FRAME_START;
        if (wordWrite) begin
          index_d = 3'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        bus.word_out = payloadWord;
        if (wordWrite) begin
          if (index_q == 3'd5) begin
            index_d    = 3'd0;
            triCount_d = triCount_q + 16'd1;
            state_d    = last_q ? S_END : S_IDLE;
          end else begin
            index_d = index_q + 3'd1;
          end
        end
      end
      S_END: begin
        bus.word_out = FRAME_END;
        if (wordWrite) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs straight from registered state.
  always_comb begin
    bus.word_write = wordWrite;
    bus.busy       = (state_q != S_IDLE);
    bus.tri_count  = triCount_q;
  end

endmodule
